// File: rtl/lsu_mem_hs.sv
// Handshaked load/store unit: accepts one request at a time, checks alignment,
// performs a single memory access after LATENCY cycles and returns extended load data.
module lsu_mem_hs #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              pmem_en,
  output logic              pmem_we,
  output logic [31:0]       pmem_addr,
  output logic [31:0]       pmem_wdata,
  output logic [2:0]        pmem_len,
  input  logic [31:0]       pmem_rdata,
  output logic [1:0]        state_dbg
);

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the sender holds valid and its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  ctr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        acc_we;
  logic [2:0]  acc_ctr;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        req_err;
  logic        direct_access;
  logic        last_wait;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  logic [31:0] load_data;
  logic [31:0] resp_d;

  function automatic logic is_err(input logic [2:0] ctr, input logic [1:0] a);
    case (ctr)
      3'b000, 3'b100: is_err = 1'b0;
      3'b001, 3'b101: is_err = a[0];
      3'b010:         is_err = (a != 2'b00);
      default:        is_err = 1'b1;
    endcase
  endfunction

  assign req_ready = rst_n && (state == IDLE);
  assign req_err   = is_err(req_ctr, req_addr[1:0]);
  assign state_dbg = state;

  // The access sees live request fields on the accept edge (LATENCY=1) and latched ones afterwards.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_ctr   = req_ctr;
      acc_addr  = 32'(req_addr);
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_ctr   = ctr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign direct_access = (state == IDLE) && req_valid && !req_err && (LATENCY == 1);
  assign last_wait     = (state == WAIT) && (cnt == 8'd1);

  assign pmem_en    = rst_n && (direct_access || last_wait);
  assign pmem_we    = acc_we;
  assign pmem_addr  = acc_we ? acc_addr : {acc_addr[31:2], 2'b00};
  assign pmem_wdata = acc_wdata;

  always_comb begin
    case (acc_ctr[1:0])
      2'b00:   pmem_len = 3'd1;
      2'b01:   pmem_len = 3'd2;
      default: pmem_len = 3'd4;
    endcase
  end

  always_comb begin
    byte_l = pmem_rdata[{acc_addr[1:0], 3'b000} +: 8];
    half_l = acc_addr[1] ? pmem_rdata[31:16] : pmem_rdata[15:0];
    case (acc_ctr)
      3'b000:  load_data = {{24{byte_l[7]}}, byte_l};
      3'b100:  load_data = {24'd0, byte_l};
      3'b001:  load_data = {{16{half_l[15]}}, half_l};
      3'b101:  load_data = {16'd0, half_l};
      3'b010:  load_data = pmem_rdata;
      default: load_data = 32'd0;
    endcase
    resp_d = acc_we ? 32'd0 : load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      we_q       <= 1'b0;
      ctr_q      <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            ctr_q   <= req_ctr;
            addr_q  <= 32'(req_addr);
            wdata_q <= req_wdata;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= resp_d;
            end else begin
              cnt   <= 8'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // The access edge is the one that takes the counter to zero.
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= resp_d;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_hs.sv
// Bench for lsu_mem_hs: a LATENCY=3 and a LATENCY=1 instance share one word-array memory;
// expected responses are queued at issue and compared when the response appears.
module tb_lsu_mem_hs;
  localparam int W = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_ctr   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        pm_en     [2];
  logic        pm_we     [2];
  logic [31:0] pm_addr   [2];
  logic [31:0] pm_wdata  [2];
  logic [2:0]  pm_len    [2];
  logic [31:0] pm_rdata  [2];
  logic [1:0]  state_dbg [2];

  logic [31:0] mem [64];
  int rd_cnt[2];
  int wr_cnt[2];
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  lsu_mem_hs #(.LATENCY(3), .ADDR_W(32)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_ctr(req_ctr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .pmem_en(pm_en[0]), .pmem_we(pm_we[0]), .pmem_addr(pm_addr[0]),
    .pmem_wdata(pm_wdata[0]), .pmem_len(pm_len[0]), .pmem_rdata(pm_rdata[0]),
    .state_dbg(state_dbg[0]));

  lsu_mem_hs #(.LATENCY(1), .ADDR_W(32)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_ctr(req_ctr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .pmem_en(pm_en[1]), .pmem_we(pm_we[1]), .pmem_addr(pm_addr[1]),
    .pmem_wdata(pm_wdata[1]), .pmem_len(pm_len[1]), .pmem_rdata(pm_rdata[1]),
    .state_dbg(state_dbg[1]));

  // Memory model: word array indexed by addr[7:2], byte-lane writes of len bytes.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [2:0] len);
    logic [31:0] r;
    logic [31:0] sh;
    r  = old;
    sh = wd << (8 * int'(off));
    for (int b = 0; b < 4; b++)
      if (b >= int'(off) && b < int'(off) + int'(len)) r[8*b +: 8] = sh[8*b +: 8];
    return r;
  endfunction

  assign pm_rdata[0] = mem[pm_addr[0][7:2]];
  assign pm_rdata[1] = mem[pm_addr[1][7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (pm_en[g]) begin
        if (pm_we[g]) begin
          wr_cnt[g] <= wr_cnt[g] + 1;
          mem[pm_addr[g][7:2]] <= merge(mem[pm_addr[g][7:2]], pm_wdata[g], pm_addr[g][1:0], pm_len[g]);
        end else begin
          rd_cnt[g] <= rd_cnt[g] + 1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int sel, input logic we, input logic [2:0] ctr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [W-1:0] exp, output int t_acc);
    int guard = 0;
    while (!req_ready[sel] && guard < 50) begin
      tick();
      guard++;
    end
    if (!req_ready[sel]) begin
      n_checks++;
      $display("FAIL issue_ready: req_ready=0 required 1 within 50 cycles");
      t_acc = -1;
      return;
    end
    req_we[sel]    = we;
    req_ctr[sel]   = ctr;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    req_valid[sel] = 1'b1;
    tick();
    t_acc = cyc;
    exp_q.push_back(exp);
    req_valid[sel] = 1'b0;
    req_we[sel]    = 1'($urandom_range(0, 1));
    req_ctr[sel]   = 3'($urandom_range(0, 7));
    req_addr[sel]  = $urandom;
    req_wdata[sel] = $urandom;
  endtask

  task automatic get_resp(input int sel, output logic [31:0] rdata, output logic err,
                          output int t_resp, output bit ok);
    int guard = 0;
    while (!resp_valid[sel] && guard < 50) begin
      tick();
      guard++;
    end
    ok     = resp_valid[sel];
    rdata  = resp_rdata[sel];
    err    = resp_err[sel];
    t_resp = cyc + 1;
    if (!ok) begin
      n_checks++;
      $display("FAIL resp_timeout: resp_valid=0 required 1 within 50 cycles");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_ctr[s] = 3'd0;
      req_addr[s] = 32'd0; req_wdata[s] = 32'd0; resp_ready[s] = 1'b1;
    end
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({resp_valid[s], resp_err[s], resp_rdata[s]} !== 34'd0)
        $display("FAIL reset_resp[%0d]: valid=%0b err=%0b rdata=%08h required 0/0/0", s, resp_valid[s], resp_err[s], resp_rdata[s]);
      else n_pass++;
      n_checks++;
      if (req_ready[s] !== 1'b0) $display("FAIL reset_req_ready[%0d]: got %0b required 0", s, req_ready[s]);
      else n_pass++;
      n_checks++;
      if (state_dbg[s] !== 2'd0) $display("FAIL reset_state[%0d]: got %0d required 0", s, state_dbg[s]);
      else n_pass++;
    end
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (req_ready[s] !== 1'b1) $display("FAIL ready_after_reset[%0d]: got %0b required 1", s, req_ready[s]);
      else n_pass++;
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic err; bit ok; int t_a, t_r, rd0, wr0; logic [W-1:0] e;
    logic        t_we[2]   = '{1'b1, 1'b0};
    logic [31:0] t_exp[2]  = '{32'h0, 32'hDEAD_BEEF};
    for (int i = 0; i < 2; i++) begin
      rd0 = rd_cnt[0]; wr0 = wr_cnt[0];
      issue(0, t_we[i], 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, {1'b0, t_exp[i]}, t_a);
      get_resp(0, rd, err, t_r, ok);
      if (ok) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({err, rd} !== e) $display("FAIL store_load[%0d]: got err=%0b rdata=%08h required err=%0b rdata=%08h", i, err, rd, e[32], e[31:0]);
        else n_pass++;
        n_checks++;
        if (t_r - t_a !== 3) $display("FAIL store_load_latency[%0d]: got %0d required 3", i, t_r - t_a);
        else n_pass++;
      end
      tick();
      n_checks++;
      if (rd_cnt[0] - rd0 !== (t_we[i] ? 0 : 1) || wr_cnt[0] - wr0 !== (t_we[i] ? 1 : 0))
        $display("FAIL store_load_calls[%0d]: got reads=%0d writes=%0d required %0d/%0d", i, rd_cnt[0] - rd0, wr_cnt[0] - wr0, t_we[i] ? 0 : 1, t_we[i] ? 1 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_extract();
    logic [31:0] rd; logic err; bit ok; int t_a, t_r; logic [W-1:0] e;
    logic        t_we  [9] = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
    logic [2:0]  t_ctr [9] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b001, 3'b001};
    logic [7:0]  t_off [9] = '{8'h20, 8'h23, 8'h23, 8'h22, 8'h20, 8'h21, 8'h20, 8'h22, 8'h22};
    logic [31:0] t_wd  [9] = '{32'h8001_FF7F, 0, 0, 0, 0, 32'h1234_56AB, 0, 32'h5555_CAFE, 0};
    logic [31:0] t_exp [9] = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_FF7F,
                               32'h0, 32'h8001_AB7F, 32'h0, 32'hFFFF_CAFE};
    for (int i = 0; i < 9; i++) begin
      issue(0, t_we[i], t_ctr[i], {24'h800000, t_off[i]}, t_wd[i], {1'b0, t_exp[i]}, t_a);
      get_resp(0, rd, err, t_r, ok);
      if (ok) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({err, rd} !== e) $display("FAIL extract[%0d]: got err=%0b rdata=%08h required err=%0b rdata=%08h", i, err, rd, e[32], e[31:0]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; bit ok; int t_a, t_r, rd0, wr0; logic [W-1:0] e;
    logic        t_we  [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [2:0]  t_ctr [7] = '{3'b010, 3'b001, 3'b011, 3'b110, 3'b111, 3'b101, 3'b010};
    logic [7:0]  t_off [7] = '{8'h02, 8'h01, 8'h10, 8'h10, 8'h10, 8'h23, 8'h11};
    for (int i = 0; i < 7; i++) begin
      rd0 = rd_cnt[0]; wr0 = wr_cnt[0];
      issue(0, t_we[i], t_ctr[i], {24'h800000, t_off[i]}, 32'hFFFF_FFFF, {1'b1, 32'h0}, t_a);
      get_resp(0, rd, err, t_r, ok);
      if (ok) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({err, rd} !== e) $display("FAIL error_resp[%0d]: got err=%0b rdata=%08h required err=%0b rdata=%08h", i, err, rd, e[32], e[31:0]);
        else n_pass++;
        n_checks++;
        if (t_r - t_a !== 1) $display("FAIL error_latency[%0d]: got %0d required 1", i, t_r - t_a);
        else n_pass++;
      end
      tick();
      n_checks++;
      if (rd_cnt[0] !== rd0 || wr_cnt[0] !== wr0)
        $display("FAIL error_calls[%0d]: got reads=%0d writes=%0d required 0/0", i, rd_cnt[0] - rd0, wr_cnt[0] - wr0);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d; logic err; bit ok; int t_a, t_r, lane; logic [W-1:0] e;
    for (int i = 0; i < 5; i++) begin
      a    = 32'h8000_0080 + 32'(4 * $urandom_range(0, 31));
      d    = $urandom;
      lane = $urandom_range(0, 3);
      issue(0, 1'b1, 3'b010, a, d, {1'b0, 32'h0}, t_a);
      get_resp(0, rd, err, t_r, ok);
      if (ok) void'(exp_q.pop_front());
      tick();
      issue(0, 1'b0, 3'b100, a + 32'(lane), 32'h0, {1'b0, 24'h0, d[8*lane +: 8]}, t_a);
      get_resp(0, rd, err, t_r, ok);
      if (ok) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({err, rd} !== e) $display("FAIL random_lbu[%0d]: got err=%0b rdata=%08h required err=%0b rdata=%08h", i, err, rd, e[32], e[31:0]);
        else n_pass++;
      end
      tick();
      issue(0, 1'b0, 3'b001, a + 32'(lane & 2), 32'h0,
            {1'b0, {16{d[16*(lane/2) + 15]}}, d[16*(lane/2) +: 16]}, t_a);
      get_resp(0, rd, err, t_r, ok);
      if (ok) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({err, rd} !== e) $display("FAIL random_lh[%0d]: got err=%0b rdata=%08h required err=%0b rdata=%08h", i, err, rd, e[32], e[31:0]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic err; bit ok; int t_a, t_r, rd0, wr0; logic [W-1:0] e;
    e = '0;
    rd0 = rd_cnt[0]; wr0 = wr_cnt[0];
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 3'b010, 32'h8000_0010, 32'h0, {1'b0, 32'hDEAD_BEEF}, t_a);
    get_resp(0, rd, err, t_r, ok);
    if (ok) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({err, rd} !== e) $display("FAIL bp_resp: got err=%0b rdata=%08h required err=%0b rdata=%08h", err, rd, e[32], e[31:0]);
      else n_pass++;
    end
    // A competing store offered during the stall must be ignored.
    req_we[0] = 1'b1; req_ctr[0] = 3'b010; req_addr[0] = 32'h8000_0010;
    req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (resp_valid[0] !== 1'b1 || {resp_err[0], resp_rdata[0]} !== e)
        $display("FAIL bp_hold[%0d]: got valid=%0b err=%0b rdata=%08h required 1/%0b/%08h", k, resp_valid[0], resp_err[0], resp_rdata[0], e[32], e[31:0]);
      else n_pass++;
      n_checks++;
      if (req_ready[0] !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %0b required 0", k, req_ready[0]);
      else n_pass++;
      n_checks++;
      if (rd_cnt[0] - rd0 !== 1 || wr_cnt[0] !== wr0)
        $display("FAIL bp_calls[%0d]: got reads=%0d writes=%0d required 1/0", k, rd_cnt[0] - rd0, wr_cnt[0] - wr0);
      else n_pass++;
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    tick();
    n_checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || state_dbg[0] !== 2'd0)
      $display("FAIL bp_release: got valid=%0b ready=%0b state=%0d required 0/1/0", resp_valid[0], req_ready[0], state_dbg[0]);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic err; bit ok; int t_a, t_r, wr0; logic [W-1:0] e;
    issue(0, 1'b1, 3'b010, 32'h8000_0030, 32'h0BAD_F00D, {1'b0, 32'h0}, t_a);
    get_resp(0, rd, err, t_r, ok);
    if (ok) void'(exp_q.pop_front());
    tick();
    wr0 = wr_cnt[0];
    issue(0, 1'b1, 3'b010, 32'h8000_0030, 32'h1234_5678, {1'b0, 32'h0}, t_a);
    tick();
    rst_n = 1'b0;
    tick();
    if (t_a >= 0) void'(exp_q.pop_back());
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (resp_valid[0] !== 1'b0 || wr_cnt[0] !== wr0)
        $display("FAIL midop_reset[%0d]: got valid=%0b writes=%0d required 0/0", k, resp_valid[0], wr_cnt[0] - wr0);
      else n_pass++;
      tick();
    end
    issue(0, 1'b0, 3'b010, 32'h8000_0030, 32'h0, {1'b0, 32'h0BAD_F00D}, t_a);
    get_resp(0, rd, err, t_r, ok);
    if (ok) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({err, rd} !== e) $display("FAIL midop_reload: got err=%0b rdata=%08h required err=%0b rdata=%08h", err, rd, e[32], e[31:0]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; bit ok; int t_a, t_r, pa, pr; logic [W-1:0] e;
    logic [2:0]  t_ctr [4] = '{3'b010, 3'b010, 3'b010, 3'b100};
    logic [7:0]  t_off [4] = '{8'h10, 8'h20, 8'h30, 8'h13};
    logic [31:0] t_exp [4] = '{32'hDEAD_BEEF, 32'hCAFE_AB7F, 32'h0BAD_F00D, 32'h0000_00DE};
    pa = 0; pr = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b0, t_ctr[i], {24'h800000, t_off[i]}, 32'h0, {1'b0, t_exp[i]}, t_a);
      get_resp(1, rd, err, t_r, ok);
      if (ok) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({err, rd} !== e) $display("FAIL b2b_data[%0d]: got err=%0b rdata=%08h required err=%0b rdata=%08h", i, err, rd, e[32], e[31:0]);
        else n_pass++;
        n_checks++;
        if (t_r - t_a !== 1) $display("FAIL b2b_latency[%0d]: got %0d required 1", i, t_r - t_a);
        else n_pass++;
        if (i > 0) begin
          n_checks++;
          if (t_a - pa !== 2 || t_r - pr !== 2)
            $display("FAIL b2b_spacing[%0d]: got accept=%0d resp=%0d required 2/2", i, t_a - pa, t_r - pr);
          else n_pass++;
        end
      end
      pa = t_a; pr = t_r;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extract();
    test_errors();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
